// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared constants and types for the fetch stage.
//   FETCH_AWIDTH / FETCH_DWIDTH : widths of the queued {pc, insn} entry
//   NOP_INSN                    : instruction shown on insn_o while the queue is empty
//   FETCH_BASEADDR              : default PC after reset
//   fetch_entry_t               : one queued fetch result
package fetch_pkg;

    localparam int FETCH_AWIDTH = 32;
    localparam int FETCH_DWIDTH = 32;

    localparam logic [FETCH_DWIDTH-1:0] NOP_INSN       = 32'h0000_0013;
    localparam logic [FETCH_AWIDTH-1:0] FETCH_BASEADDR = 32'h0100_0000;

    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] pc;
        logic [FETCH_DWIDTH-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if
//   Bundles the fetch stage's instruction-memory bus, redirect input and
//   decode-side handshake.
//   master : the fetch unit (drives imem_req_o/imem_addr_o, valid_o, pc_o, insn_o, misalign_o)
//   slave  : memory + execute + decode environment (drives grant, response, redirect, ready)
interface fetch_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              imem_req_o;
    logic [AWIDTH-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [DWIDTH-1:0] imem_rdata_i;
    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              valid_o;
    logic              ready_i;
    logic [AWIDTH-1:0] pc_o;
    logic [DWIDTH-1:0] insn_o;
    logic              misalign_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        output valid_o,
        input  ready_i,
        output pc_o, insn_o, misalign_o
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        input  valid_o,
        output ready_i,
        input  pc_o, insn_o, misalign_o
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Synchronous in-order FIFO with flush and occupancy output.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push_i   : write data_i (ignored when full or flushing)
//   pop_i    : drop head entry (ignored when empty or flushing)
//   flush_i  : empty the FIFO next cycle
//   data_o   : head entry (contents undefined while empty)
//   count_o  : number of stored entries
//   empty_o  : no entries stored
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && (count_q != CW'(DEPTH)) && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Pointer/occupancy update; flush wins over push and pop in the same cycle.
    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Fetch stage: issues sequential instruction-memory requests, tags each
//   grant with its PC, queues returned words and offers {pc, insn} to decode.
//   A redirect flushes the queue and discards responses still in flight.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : fetch_if.master -- imem request/grant/response, redirect,
//                decode valid/ready with pc_o/insn_o, misalign_o
//   Optional feature (macro FETCH_MISALIGN_CHK_EN):
//     defined   : a redirect to a target with nonzero low bits raises sticky
//                 misalign_o, shows the target on pc_o and stalls fetch until
//                 an aligned redirect or reset.
//     undefined : redirect target low bits are cleared, misalign_o is 0.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DWIDTH   = FETCH_DWIDTH,
    parameter int                AWIDTH   = FETCH_AWIDTH,
    parameter logic [AWIDTH-1:0] BASEADDR = FETCH_BASEADDR,
    parameter int                DEPTH    = 4
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam int             EW      = AWIDTH + DWIDTH;
    localparam logic [CW:0]    CREDITS = (CW + 1)'(DEPTH);

    logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [AWIDTH-1:0] redirect_tgt;
    logic              fetch_halt;
    logic              grant, drop_now, data_push, data_pop;
    logic [CW-1:0]     data_count, tag_count;
    logic              data_empty, tag_empty;
    logic [AWIDTH-1:0] tag_pc;
    logic [CW:0]       inflight;
    fetch_entry_t      push_entry, head_entry;

`ifdef FETCH_MISALIGN_CHK_EN
    logic              misalign_q, misalign_d;
    logic [AWIDTH-1:0] bad_pc_q, bad_pc_d;

    assign redirect_tgt   = bus.redirect_pc_i;
    assign fetch_halt     = misalign_q;
    assign bus.misalign_o = misalign_q;
    assign bus.pc_o       = misalign_q ? bad_pc_q : (data_empty ? '0 : head_entry.pc);

    // Every redirect re-evaluates alignment, so an aligned one clears the flag.
    always_comb begin
        misalign_d = misalign_q;
        bad_pc_d   = bad_pc_q;
        if (bus.redirect_i) begin
            misalign_d = (bus.redirect_pc_i[1:0] != 2'b00);
            bad_pc_d   = bus.redirect_pc_i;
        end
    end

    // Misalign flag and offending target.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
            bad_pc_q   <= '0;
        end else begin
            misalign_q <= misalign_d;
            bad_pc_q   <= bad_pc_d;
        end
    end
`else
    assign redirect_tgt   = bus.redirect_pc_i & ~AWIDTH'(3);
    assign fetch_halt     = 1'b0;
    assign bus.misalign_o = 1'b0;
    assign bus.pc_o       = data_empty ? '0 : head_entry.pc;
`endif

    // Queued entries plus in-flight requests never exceed DEPTH, so every
    // response is guaranteed a free queue slot.
    assign inflight        = {1'b0, data_count} + {1'b0, tag_count};
    assign bus.imem_req_o  = !rst && !bus.redirect_i && !fetch_halt && (inflight < CREDITS);
    assign bus.imem_addr_o = fetch_pc_q;
    assign grant           = bus.imem_req_o && bus.imem_gnt_i;

    assign drop_now   = bus.imem_rvalid_i && (drop_cnt_q != '0);
    assign data_push  = bus.imem_rvalid_i && !drop_now && !bus.redirect_i;
    assign data_pop   = bus.valid_o && bus.ready_i;
    assign push_entry = '{pc: tag_pc, insn: bus.imem_rdata_i};

    assign bus.valid_o = !data_empty && !fetch_halt;
    assign bus.insn_o  = data_empty ? NOP_INSN : head_entry.insn;

    // Next fetch PC and drop count. The tag queue occupancy is the number of
    // outstanding requests; on a redirect every request still unanswered after
    // this cycle's response must be discarded when it returns.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (grant)    fetch_pc_d = fetch_pc_q + AWIDTH'(4);
        if (drop_now) drop_cnt_d = drop_cnt_q - CW'(1);
        if (bus.redirect_i) begin
            fetch_pc_d = redirect_tgt;
            drop_cnt_d = tag_count - CW'(bus.imem_rvalid_i);
        end
    end

    // Fetch PC and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= BASEADDR;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // In-order PC tags, written at grant and retired by each response
    // (dropped or not), so the head always belongs to the current response.
    fetch_fifo #(.WIDTH(AWIDTH), .DEPTH(DEPTH)) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (grant),
        .data_i  (fetch_pc_q),
        .pop_i   (bus.imem_rvalid_i),
        .flush_i (1'b0),
        .data_o  (tag_pc),
        .count_o (tag_count),
        .empty_o (tag_empty)
    );

    // Fetched {pc, insn} entries waiting for decode.
    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_data_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (data_push),
        .data_i  (push_entry),
        .pop_i   (data_pop),
        .flush_i (bus.redirect_i),
        .data_o  (head_entry),
        .count_o (data_count),
        .empty_o (data_empty)
    );

    // A response with nothing outstanding means the memory side is broken.
    rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rvalid_i && tag_empty));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed bench for fetch_unit with a behavioural instruction memory of
//   programmable response latency. Each task drives one scenario and checks
//   outputs on the falling clock edge.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] BASE = 32'h0100_0000;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } pend_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    vectors = 0;
    int    miscompares = 0;
    int    mem_lat = 1;
    int unsigned cyc = 0;
    pend_t pend_q[$];

    fetch_if bus ();

    fetch_unit #(
        .DWIDTH   (32),
        .AWIDTH   (32),
        .BASEADDR (BASE),
        .DEPTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    // Memory model: a grant at cycle k answers in cycle k+mem_lat, in order.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            pend_q.delete();
        end else begin
            if (bus.imem_rvalid_i && pend_q.size() > 0) pend_q.delete(0);
            if (bus.imem_req_o && bus.imem_gnt_i)
                pend_q.push_back('{due: cyc + mem_lat, addr: bus.imem_addr_o});
        end
        #1;
        if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_word(pend_q[0].addr);
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end
    end

    // Holds reset for two cycles and releases it at a falling edge; the
    // caller then sits in cycle 1 with gnt=1 and ready=1.
    task automatic do_reset(input int lat);
        @(negedge clk);
        rst = 1'b1;
        bus.imem_gnt_i    = 1'b0;
        bus.ready_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        mem_lat = lat;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.imem_gnt_i = 1'b1;
        bus.ready_i    = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        bus.imem_gnt_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %0b want 0", bus.valid_o); end
        vectors++;
        if (bus.imem_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req: got %0b want 0", bus.imem_req_o); end
        vectors++;
        if (bus.misalign_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_misalign: got %0b want 0", bus.misalign_o); end
        vectors++;
        if (bus.pc_o !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_pc: got %h want 00000000", bus.pc_o); end
        vectors++;
        if (bus.insn_o !== 32'h0000_0013) begin miscompares++; $display("[TB] FAIL rst_insn: got %h want 00000013", bus.insn_o); end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_pc;
        do_reset(1);
        vectors++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== BASE) begin
            miscompares++; $display("[TB] FAIL seq_first_req: req=%0b addr=%h want 1/%h", bus.imem_req_o, bus.imem_addr_o, BASE);
        end
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL seq_valid_c2: got %0b want 0", bus.valid_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_pc = BASE + 32'(4 * i);
            vectors++;
            if (bus.valid_o !== 1'b1 || bus.pc_o !== exp_pc || bus.insn_o !== mem_word(exp_pc)) begin
                miscompares++;
                $display("[TB] FAIL seq_entry%0d: valid=%0b pc=%h insn=%h want 1/%h/%h", i, bus.valid_o, bus.pc_o, bus.insn_o, exp_pc, mem_word(exp_pc));
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_pc;
        int seen;
        do_reset(1);
        bus.ready_i = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.imem_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_req_full: got %0b want 0", bus.imem_req_o); end
        vectors++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== BASE) begin
            miscompares++; $display("[TB] FAIL bp_head: valid=%0b pc=%h want 1/%h", bus.valid_o, bus.pc_o, BASE);
        end
        bus.ready_i = 1'b1;
        exp_pc = BASE;
        seen = 0;
        for (int c = 0; c < 40 && seen < 6; c++) begin
            if (bus.valid_o) begin
                vectors++;
                if (bus.pc_o !== exp_pc || bus.insn_o !== mem_word(exp_pc)) begin
                    miscompares++;
                    $display("[TB] FAIL bp_drain%0d: pc=%h insn=%h want %h/%h", seen, bus.pc_o, bus.insn_o, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
            @(negedge clk);
        end
        vectors++;
        if (seen != 6) begin miscompares++; $display("[TB] FAIL bp_drain_count: got %0d want 6", seen); end
    endtask

    task automatic test_grant_stall;
        do_reset(1);
        bus.imem_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== BASE || bus.valid_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stall_c%0d: req=%0b addr=%h valid=%0b want 1/%h/0", i + 1, bus.imem_req_o, bus.imem_addr_o, bus.valid_o, BASE);
            end
        end
        bus.imem_gnt_i = 1'b1;
    endtask

    task automatic test_redirect_drop;
        logic found;
        do_reset(3);
        repeat (2) @(negedge clk);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h0100_0100;
        #1;
        vectors++;
        if (bus.imem_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_req: got %0b want 0", bus.imem_req_o); end
        @(negedge clk);
        bus.redirect_i = 1'b0;
        vectors++;
        if (bus.valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_valid_after: got %0b want 0", bus.valid_o); end
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (bus.valid_o) found = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!found || bus.pc_o !== 32'h0100_0100 || bus.insn_o !== mem_word(32'h0100_0100)) begin
            miscompares++;
            $display("[TB] FAIL redir_first: found=%0b pc=%h insn=%h want 1/01000100/%h", found, bus.pc_o, bus.insn_o, mem_word(32'h0100_0100));
        end
    endtask

    task automatic test_back_to_back_redirect;
        logic [31:0] exp_pc;
        int seen;
        do_reset(3);
        @(negedge clk);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h0100_0200;
        #1;
        vectors++;
        if (bus.imem_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_req1: got %0b want 0", bus.imem_req_o); end
        @(negedge clk);
        bus.redirect_pc_i = 32'h0100_0300;
        #1;
        vectors++;
        if (bus.imem_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_req2: got %0b want 0", bus.imem_req_o); end
        @(negedge clk);
        bus.redirect_i = 1'b0;
        exp_pc = 32'h0100_0300;
        seen = 0;
        for (int c = 0; c < 40 && seen < 3; c++) begin
            if (bus.valid_o) begin
                vectors++;
                if (bus.pc_o !== exp_pc || bus.insn_o !== mem_word(exp_pc)) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_entry%0d: pc=%h insn=%h want %h/%h", seen, bus.pc_o, bus.insn_o, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
            @(negedge clk);
        end
        vectors++;
        if (seen != 3) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d want 3", seen); end
    endtask

    task automatic test_misalign;
        logic found;
        do_reset(1);
        repeat (2) @(negedge clk);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h0100_0102;
        @(negedge clk);
        bus.redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if (bus.misalign_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.imem_req_o !== 1'b0 || bus.pc_o !== 32'h0100_0102) begin
                miscompares++;
                $display("[TB] FAIL misalign_hold%0d: mis=%0b valid=%0b req=%0b pc=%h want 1/0/0/01000102", i, bus.misalign_o, bus.valid_o, bus.imem_req_o, bus.pc_o);
            end
        end
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h0100_0100;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        vectors++;
        if (bus.misalign_o !== 1'b0) begin miscompares++; $display("[TB] FAIL misalign_clear: got %0b want 0", bus.misalign_o); end
`else
        vectors++;
        if (bus.misalign_o !== 1'b0) begin miscompares++; $display("[TB] FAIL misalign_tied: got %0b want 0", bus.misalign_o); end
`endif
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (bus.valid_o) found = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!found || bus.pc_o !== 32'h0100_0100 || bus.insn_o !== mem_word(32'h0100_0100)) begin
            miscompares++;
            $display("[TB] FAIL misalign_resume: found=%0b pc=%h insn=%h want 1/01000100/%h", found, bus.pc_o, bus.insn_o, mem_word(32'h0100_0100));
        end
    endtask

    task automatic test_reset_mid;
        do_reset(3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_lat = 1;
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midrst_state: valid=%0b req=%0b want 0/0", bus.valid_o, bus.imem_req_o);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== BASE) begin
            miscompares++; $display("[TB] FAIL midrst_req: req=%0b addr=%h want 1/%h", bus.imem_req_o, bus.imem_addr_o, BASE);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== BASE || bus.insn_o !== mem_word(BASE)) begin
            miscompares++;
            $display("[TB] FAIL midrst_first: valid=%0b pc=%h insn=%h want 1/%h/%h", bus.valid_o, bus.pc_o, bus.insn_o, BASE, mem_word(BASE));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.ready_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_grant_stall();
        test_redirect_drop();
        test_back_to_back_redirect();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
